// File: rtl/selector_distributor.sv
// Registered 1-to-N distributor: latches one word into the addressed output slot
// and holds that slot's Valid until its consumer acknowledges.
module selector_distributor #(
   parameter int bits     = 16,
   parameter int outputs  = 2,
   parameter int sel_bits = 1,
   parameter int cnt_bits = 8
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [bits-1:0]           Input,
   input  logic [sel_bits-1:0]       Sel,
   input  logic                      In_Valid,
   output logic                      In_Ready,
   output logic [outputs*bits-1:0]   Output,
   output logic [outputs-1:0]        Valid,
   input  logic [outputs-1:0]        Ack,
   output logic                      Err,
   output logic [cnt_bits-1:0]       Count
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [sel_bits:0] num_slots = (sel_bits+1)'(outputs);

   state_t state;
   logic   sel_ok;
   logic   ack_hit;

   assign sel_ok   = {1'b0, Sel} < num_slots;
   // Valid is one-hot on the latched slot, so masking Ack with it isolates that slot's acknowledge.
   assign ack_hit  = |(Ack & Valid);
   assign In_Ready = (state == IDLE) && Reset;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state  <= IDLE;
         Output <= '0;
         Valid  <= '0;
         Err    <= 1'b0;
         Count  <= '0;
      end else begin
         Err <= 1'b0;
         case (state)
            IDLE: begin
               if (In_Valid) begin
                  if (sel_ok) begin
                     for (int k = 0; k < outputs; k++) begin
                        if (Sel == sel_bits'(k)) begin
                           Output[k*bits +: bits] <= Input;
                        end
                     end
                     Valid <= outputs'(1) << Sel;
                     state <= HOLD;
                  end else begin
                     Err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (ack_hit) begin
                  Valid <= '0;
                  Count <= Count + cnt_bits'(1);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_selector_distributor.sv
// Scoreboard bench for selector_distributor (3 slots, 2-bit counter): stimulus pushes
// expected events, a negedge monitor pops them when Valid rises/falls or Err pulses.
module tb_selector_distributor;

   localparam int EV_XFER = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int          kind;
      logic [2:0]  valid;
      logic [47:0] out;
      logic [1:0]  count;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] Input;
   logic [1:0]  Sel;
   logic        In_Valid;
   logic        In_Ready;
   logic [47:0] Output;
   logic [2:0]  Valid;
   logic [2:0]  Ack;
   logic        Err;
   logic [1:0]  Count;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   mon_on       = 1'b0;

   selector_distributor #(
      .bits(16), .outputs(3), .sel_bits(2), .cnt_bits(2)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Input(Input), .Sel(Sel), .In_Valid(In_Valid),
      .In_Ready(In_Ready), .Output(Output), .Valid(Valid), .Ack(Ack),
      .Err(Err), .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [2:0] valid, input logic [47:0] out,
                       input logic [1:0] count);
      exp_t e;
      e.kind  = kind;
      e.valid = valid;
      e.out   = out;
      e.count = count;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data);
      Sel      = sel;
      Input    = data;
      In_Valid = 1'b1;
      tick();
      In_Valid = 1'b0;
   endtask

   task automatic ack_slot(input logic [2:0] a);
      Ack = a;
      tick();
      Ack = 3'b000;
   endtask

   task automatic pop_and_check(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_event", 64'(kind), 64'hFF);
      end else begin
         e = exp_q.pop_front();
         checkOutput("event_kind", 64'(kind), 64'(e.kind));
         checkOutput("event_valid", 64'(Valid), 64'(e.valid));
         checkOutput("event_output", 64'(Output), 64'(e.out));
         checkOutput("event_count", 64'(Count), 64'(e.count));
         if (kind == EV_XFER) checkOutput("hold_in_ready", 64'(In_Ready), 64'd0);
         if (kind == EV_ERR)  checkOutput("err_in_ready", 64'(In_Ready), 64'd1);
      end
   endtask

   // Monitor: one expected event per Err pulse, Valid rising edge and Valid falling edge.
   initial begin
      logic [2:0] prev_valid;
      prev_valid = 3'b000;
      forever begin
         @(negedge Clk);
         if (mon_on) begin
            if (Err === 1'b1) pop_and_check(EV_ERR);
            if (Valid != 3'b000 && prev_valid == 3'b000) pop_and_check(EV_XFER);
            else if (Valid == 3'b000 && prev_valid != 3'b000) pop_and_check(EV_DONE);
            prev_valid = Valid;
         end
      end
   end

   initial begin
      Reset    = 1'b0;
      In_Valid = 1'b1;
      Input    = 16'h1234;
      Sel      = 2'd0;
      Ack      = 3'b000;

      tick();
      tick();
      checkOutput("reset_in_ready_low", 64'(In_Ready), 64'd0);
      Reset    = 1'b1;
      In_Valid = 1'b0;
      #1;
      checkOutput("reset_output", 64'(Output), 64'd0);
      checkOutput("reset_valid", 64'(Valid), 64'd0);
      checkOutput("reset_count", 64'(Count), 64'd0);
      checkOutput("reset_err", 64'(Err), 64'd0);
      checkOutput("reset_in_ready", 64'(In_Ready), 64'd1);
      mon_on = 1'b1;

      // Basic transfer into slot 0
      push(EV_XFER, 3'b001, 48'h0000_0000_0001, 2'd0);
      applyStimulus(2'd0, 16'h0001);
      checkOutput("basic_in_ready", 64'(In_Ready), 64'd0);
      push(EV_DONE, 3'b000, 48'h0000_0000_0001, 2'd1);
      ack_slot(3'b001);
      checkOutput("basic_ready_again", 64'(In_Ready), 64'd1);

      // Slot 1 load, wrong ack and new requests ignored while holding
      push(EV_XFER, 3'b010, 48'h0000_0002_0001, 2'd1);
      applyStimulus(2'd1, 16'h0002);
      Ack      = 3'b001;
      Input    = 16'hFFFF;
      Sel      = 2'd0;
      In_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("freeze_valid", 64'(Valid), 64'b010);
         checkOutput("freeze_output", 64'(Output), 64'h0000_0002_0001);
         checkOutput("freeze_count", 64'(Count), 64'd1);
      end
      In_Valid = 1'b0;
      push(EV_DONE, 3'b000, 48'h0000_0002_0001, 2'd2);
      ack_slot(3'b010);

      // Back-to-back streaming with Ack held, counter wraps 3 -> 0
      push(EV_XFER, 3'b001, 48'h0000_0002_0001, 2'd2);
      push(EV_DONE, 3'b000, 48'h0000_0002_0001, 2'd3);
      push(EV_XFER, 3'b010, 48'h0000_0002_0001, 2'd3);
      push(EV_DONE, 3'b000, 48'h0000_0002_0001, 2'd0);
      push(EV_XFER, 3'b001, 48'h0000_0002_0003, 2'd0);
      push(EV_DONE, 3'b000, 48'h0000_0002_0003, 2'd1);
      push(EV_XFER, 3'b010, 48'h0000_0004_0003, 2'd1);
      push(EV_DONE, 3'b000, 48'h0000_0004_0003, 2'd2);
      Ack      = 3'b011;
      In_Valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Sel   = 2'(i % 2);
         Input = 16'(i + 1);
         tick();
         tick();
      end
      In_Valid = 1'b0;
      Ack      = 3'b000;
      checkOutput("stream_output", 64'(Output), 64'h0000_0004_0003);
      checkOutput("stream_count", 64'(Count), 64'd2);

      // Invalid select: single then back-to-back error pulses
      push(EV_ERR, 3'b000, 48'h0000_0004_0003, 2'd2);
      applyStimulus(2'd3, 16'hBEEF);
      checkOutput("err_valid", 64'(Valid), 64'd0);
      tick();
      checkOutput("err_one_cycle", 64'(Err), 64'd0);
      push(EV_ERR, 3'b000, 48'h0000_0004_0003, 2'd2);
      push(EV_ERR, 3'b000, 48'h0000_0004_0003, 2'd2);
      Sel      = 2'd3;
      In_Valid = 1'b1;
      tick();
      tick();
      In_Valid = 1'b0;
      tick();
      checkOutput("err_cleared", 64'(Err), 64'd0);

      // Ack while idle is ignored
      ack_slot(3'b111);
      checkOutput("idle_ack_count", 64'(Count), 64'd2);
      checkOutput("idle_ack_ready", 64'(In_Ready), 64'd1);

      // Slot 2 transfers, counter wraps again
      push(EV_XFER, 3'b100, 48'h00AA_0004_0003, 2'd2);
      push(EV_DONE, 3'b000, 48'h00AA_0004_0003, 2'd3);
      applyStimulus(2'd2, 16'h00AA);
      ack_slot(3'b100);
      push(EV_XFER, 3'b100, 48'h00BB_0004_0003, 2'd3);
      push(EV_DONE, 3'b000, 48'h00BB_0004_0003, 2'd0);
      applyStimulus(2'd2, 16'h00BB);
      ack_slot(3'b100);
      checkOutput("wrap_count", 64'(Count), 64'd0);

      // Reset while holding discards the pending word
      push(EV_XFER, 3'b001, 48'h00BB_0004_5555, 2'd0);
      applyStimulus(2'd0, 16'h5555);
      push(EV_DONE, 3'b000, 48'h0000_0000_0000, 2'd0);
      Reset = 1'b0;
      tick();
      checkOutput("midhold_valid", 64'(Valid), 64'd0);
      checkOutput("midhold_output", 64'(Output), 64'd0);
      checkOutput("midhold_in_ready", 64'(In_Ready), 64'd0);
      Reset = 1'b1;
      #1;
      checkOutput("midhold_idle", 64'(In_Ready), 64'd1);

      tick();
      tick();
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
